pmt_gate_count_ctrl: RTL and testbench

//  Sequences a gated up/down photon count for the PMT path. Async up/down pulses
//  are synchronised, edge-detected and arbitrated into one net increment per clk.

---
 rtl/pmt_gate_count_ctrl.sv | 116 +++++++++++
 tb/tb_pmt_gate_count_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_gate_count_ctrl.sv
// pmt_gate_count_ctrl: gated up/down photon counter with synchronised inputs and valid/ready result handoff
module pmt_gate_count_ctrl #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_in,
    input  logic              down_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic [CNT_W-1:0]  count_out,
    output logic              sat,
    output logic              result_valid,
    input  logic              result_ready
);
    typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;
    localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0]       LAST    = {{(GATE_W-1){1'b0}}, 1'b1};
    state_t                  state, state_n;
    logic [1:0]              up_sync, down_sync;
    logic                    up_hist, down_hist, up_edge, down_edge;
    logic                    step_up, step_dn;
    logic signed [CNT_W-1:0] acc, acc_n;
    logic                    acc_sat, acc_sat_n;
    logic [GATE_W-1:0]       timer, timer_n;
    logic [CNT_W-1:0]        count_n;
    logic                    sat_n, valid_n;
    // two-flop synchronisers followed by a registered rising-edge detector per channel
    always_ff @(posedge clk) begin
        if (reset) begin
            up_sync   <= '0;
            down_sync <= '0;
            up_hist   <= 1'b0;
            down_hist <= 1'b0;
            up_edge   <= 1'b0;
            down_edge <= 1'b0;
        end else begin
            up_sync   <= {up_sync[0], up_in};
            down_sync <= {down_sync[0], down_in};
            up_hist   <= up_sync[1];
            down_hist <= down_sync[1];
            up_edge   <= up_sync[1] & ~up_hist;
            down_edge <= down_sync[1] & ~down_hist;
        end
    end
    assign step_up = up_edge & ~down_edge;
    assign step_dn = down_edge & ~up_edge;
    // gate sequencing, saturating accumulation and result latching
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        acc_sat_n = acc_sat;
        timer_n   = timer;
        count_n   = count_out;
        sat_n     = sat;
        valid_n   = result_valid;
        unique case (state)
            IDLE: if (start) begin
                acc_n     = '0;
                acc_sat_n = 1'b0;
                timer_n   = gate_len;
                if (gate_len == '0) begin
                    state_n = HOLD;
                    count_n = '0;
                    sat_n   = 1'b0;
                    valid_n = 1'b1;
                end else begin
                    state_n = GATE;
                end
            end
            GATE: begin
                acc_n     = (step_up && acc != ACC_MAX) ? acc + ONE :
                            (step_dn && acc != ACC_MIN) ? acc - ONE : acc;
                acc_sat_n = acc_sat | (step_up && acc == ACC_MAX) | (step_dn && acc == ACC_MIN);
                timer_n   = timer - LAST;
                if (timer == LAST) begin
                    state_n = HOLD;
                    count_n = acc_n;
                    sat_n   = acc_sat_n;
                    valid_n = 1'b1;
                end
            end
            HOLD: if (result_ready) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and result registers; busy is registered alongside state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            acc          <= '0;
            acc_sat      <= 1'b0;
            timer        <= '0;
            count_out    <= '0;
            sat          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= state_n != IDLE;
            acc          <= acc_n;
            acc_sat      <= acc_sat_n;
            timer        <= timer_n;
            count_out    <= count_n;
            sat          <= sat_n;
            result_valid <= valid_n;
        end
    end
endmodule

// File: tb/tb_pmt_gate_count_ctrl.sv
// tb_pmt_gate_count_ctrl: directed stimulus against a 16-bit and a 4-bit counter with a per-cycle reference model
module tb_pmt_gate_count_ctrl;
    logic        clk = 1'b0;
    logic        reset, up_in, down_in, start, result_ready;
    logic [19:0] gate_len;
    logic        b16, s16, v16, b4, s4, v4;
    logic [15:0] c16;
    logic [3:0]  c4;
    int          n_pass = 0;
    int          n_total = 0;

    pmt_gate_count_ctrl #(.CNT_W(16), .GATE_W(20)) dut16 (
        .clk(clk), .reset(reset), .up_in(up_in), .down_in(down_in), .start(start),
        .gate_len(gate_len), .busy(b16), .count_out(c16), .sat(s16),
        .result_valid(v16), .result_ready(result_ready));
    pmt_gate_count_ctrl #(.CNT_W(4), .GATE_W(20)) dut4 (
        .clk(clk), .reset(reset), .up_in(up_in), .down_in(down_in), .start(start),
        .gate_len(gate_len), .busy(b4), .count_out(c4), .sat(s4),
        .result_valid(v4), .result_ready(result_ready));

    always #5 clk = ~clk;

    task automatic check(string nm, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    endtask

    // inputs as seen by the rising edge
    logic        p_rst = 1'b1;
    logic        p_up = 1'b0, p_dn = 1'b0, p_start = 1'b0, p_ready = 1'b0;
    logic [19:0] p_len = '0;
    always @(posedge clk) begin
        p_rst   <= reset;
        p_up    <= up_in;
        p_dn    <= down_in;
        p_start <= start;
        p_ready <= result_ready;
        p_len   <= gate_len;
    end

    // reference model: sample history gives edge events 3 clocks later; gate is a countdown of clocks
    int       width [2] = '{16, 4};
    int       m_mode = 0;
    int       m_rem = 0;
    int       m_valid = 0;
    int       m_acc [2] = '{0, 0};
    int       m_isat [2] = '{0, 0};
    int       m_cnt [2] = '{0, 0};
    int       m_osat [2] = '{0, 0};
    logic [4:1] hu = '0, hd = '0;
    bit       has_reset = 0;

    task automatic model_step();
        int st, mx, mn, nv;
        bit ue, de;
        ue = hu[3] & ~hu[4];
        de = hd[3] & ~hd[4];
        st = (ue && !de) ? 1 : (de && !ue) ? -1 : 0;
        if (p_rst) begin
            has_reset = 1;
            m_mode = 0; m_rem = 0; m_valid = 0; hu = '0; hd = '0;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_isat[k] = 0; m_cnt[k] = 0; m_osat[k] = 0;
            end
            return;
        end
        hu = {hu[3:1], p_up};
        hd = {hd[3:1], p_dn};
        if (m_mode == 0) begin
            if (p_start) begin
                for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_isat[k] = 0; end
                if (p_len == 0) begin
                    m_mode = 2; m_valid = 1;
                    for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_osat[k] = 0; end
                end else begin
                    m_mode = 1; m_rem = int'(p_len);
                end
            end
        end else if (m_mode == 1) begin
            for (int k = 0; k < 2; k++) begin
                mx = (1 << (width[k] - 1)) - 1;
                mn = -(1 << (width[k] - 1));
                nv = m_acc[k] + st;
                if (nv > mx) begin nv = mx; m_isat[k] = 1; end
                if (nv < mn) begin nv = mn; m_isat[k] = 1; end
                m_acc[k] = nv;
            end
            m_rem--;
            if (m_rem == 0) begin
                m_mode = 2; m_valid = 1;
                for (int k = 0; k < 2; k++) begin m_cnt[k] = m_acc[k]; m_osat[k] = m_isat[k]; end
            end
        end else if (p_ready) begin
            m_mode = 0; m_valid = 0;
        end
    endtask

    // advance the model each cycle and compare both DUTs against it
    initial forever begin
        @(negedge clk);
        model_step();
        if (has_reset) begin
            check("cyc_busy16", int'(b16), int'(m_mode != 0));
            check("cyc_valid16", int'(v16), m_valid);
            check("cyc_count16", int'($signed(c16)), m_cnt[0]);
            check("cyc_sat16", int'(s16), m_osat[0]);
            check("cyc_busy4", int'(b4), int'(m_mode != 0));
            check("cyc_valid4", int'(v4), m_valid);
            check("cyc_count4", int'($signed(c4)), m_cnt[1]);
            check("cyc_sat4", int'(s4), m_osat[1]);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic up_p();
        up_in = 1'b1; tick(1); up_in = 1'b0; tick(1);
    endtask
    task automatic dn_p();
        down_in = 1'b1; tick(1); down_in = 1'b0; tick(1);
    endtask
    task automatic both_p();
        up_in = 1'b1; down_in = 1'b1; tick(1); up_in = 1'b0; down_in = 1'b0; tick(1);
    endtask
    task automatic go(int len);
        start = 1'b1; gate_len = 20'(len); tick(1); start = 1'b0; gate_len = 20'hABCDE;
    endtask
    task automatic handshake();
        result_ready = 1'b1; tick(1); result_ready = 1'b0;
    endtask
    task automatic wait_valid(string nm);
        int n = 0;
        while (!v16 && n < 200) begin tick(1); n++; end
        check(nm, int'(v16), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; up_in = 1'b0; down_in = 1'b0; start = 1'b0;
        gate_len = '0; result_ready = 1'b0;
        tick(3);
        check("rst_busy", int'(b16), 0);
        check("rst_valid", int'(v16), 0);
        check("rst_count", int'(c16), 0);
        reset = 1'b0;
        tick(2);
        // 1: four up pulses in a 10-clock gate, result appears 10 clocks after start
        go(10);
        repeat (4) up_p();
        tick(1);
        check("t1_not_yet", int'(v16), 0);
        tick(1);
        check("t1_valid", int'(v16), 1);
        check("t1_count", int'($signed(c16)), 4);
        check("t1_sat", int'(s16), 0);
        check("t1_model", m_cnt[0], 4);
        handshake();
        // back-to-back start right after the handshake
        go(20);
        check("b2b_busy", int'(b16), 1);
        // 2: simultaneous up/down cancel, two extra ups
        repeat (3) both_p();
        repeat (2) up_p();
        wait_valid("t2_wait");
        check("t2_count", int'($signed(c16)), 2);
        handshake();
        // 3: saturation of the 4-bit counter in both directions
        go(25);
        repeat (9) up_p();
        wait_valid("t3a_wait");
        check("t3a_count4", int'($signed(c4)), 7);
        check("t3a_sat4", int'(s4), 1);
        check("t3a_count16", int'($signed(c16)), 9);
        check("t3a_model4", m_cnt[1], 7);
        handshake();
        go(25);
        repeat (10) dn_p();
        wait_valid("t3b_wait");
        check("t3b_count4", int'($signed(c4)), -8);
        check("t3b_sat4", int'(s4), 1);
        check("t3b_count16", int'($signed(c16)), -10);
        check("t3b_sat16", int'(s16), 0);
        handshake();
        // 4: zero-length gate goes straight to HOLD; valid held while ready low, start ignored
        go(0);
        check("t4_valid", int'(v16), 1);
        check("t4_busy", int'(b16), 1);
        check("t4_count", int'($signed(c16)), 0);
        for (int i = 0; i < 4; i++) begin
            go(5);
            up_p();
            tick(2);
        end
        check("t4_held_valid", int'(v16), 1);
        check("t4_held_count", int'($signed(c16)), 0);
        handshake();
        check("t4_idle", int'(b16), 0);
        // 5: pulse before start ignored, pulse on last gate clock counted, pulse after close ignored
        up_p();
        tick(4);
        go(6);
        tick(2);
        up_p();
        up_p();
        wait_valid("t5_wait");
        check("t5_count", int'($signed(c16)), 1);
        tick(4);
        check("t5_after_close", int'($signed(c16)), 1);
        handshake();
        // 6: reset mid-gate returns to IDLE and clears the result
        go(10);
        repeat (2) up_p();
        reset = 1'b1;
        tick(1);
        check("t6_busy", int'(b16), 0);
        check("t6_valid", int'(v16), 0);
        check("t6_count", int'($signed(c16)), 0);
        check("t6_count4", int'($signed(c4)), 0);
        reset = 1'b0;
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
